c_rr_packet_arbiter: RTL and testbench

Round-robin arbiter with packet locking. It shares one output resource (a switch output port or a VC buffer write port) between `num_ports` requesters. Winner selection uses a pointer-masked two-pass lowest-index one-hot priority filter. Once a requester wins with a non-tail flit, the grant is held until that requester's tail flit is granted, so flits from different packets never interleave.

---
 rtl/c_rr_packet_arbiter.sv | 119 +++++++++++
 tb/tb_c_rr_packet_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/c_rr_packet_arbiter.sv
// Round-robin arbiter with packet locking.
// Shares one output resource between num_ports requesters. An unlocked
// winner is chosen by a pointer-masked, two-pass, lowest-index priority
// filter. A winner whose flit is not a tail holds the grant until its tail
// flit is granted, so packets never interleave.
module c_rr_packet_arbiter #(
  parameter  int num_ports = 4,
  localparam int idx_width = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [num_ports-1:0] req,
  input  logic [num_ports-1:0] tail,
  input  logic                 ready,
  output logic [num_ports-1:0] gnt,
  output logic                 gnt_valid,
  output logic [idx_width-1:0] gnt_idx,
  output logic                 locked
);

  // Registered state
  logic [num_ports-1:0] r_prio;      // one-hot priority pointer
  logic                 r_locked;    // packet in progress
  logic [idx_width-1:0] r_owner;     // requester holding the lock
  logic [idx_width-1:0] r_last_idx;  // index of the most recent grant

  // Combinational arbitration signals
  logic [num_ports-1:0] w_mask;
  logic [num_ports-1:0] w_masked;
  logic [num_ports-1:0] w_owner_oh;
  logic [num_ports-1:0] w_gnt;
  logic [num_ports-1:0] w_prio_next;
  logic [idx_width-1:0] w_masked_idx;
  logic [idx_width-1:0] w_req_idx;
  logic [idx_width-1:0] w_win_idx;
  logic                 w_win_valid;
  logic                 w_win_tail;

  // Thermometer mask of indices at or above the priority pointer.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_mask = '0;
    for (int i = 0; i < num_ports; i++) begin
      acc       = acc | r_prio[i];
      w_mask[i] = acc;
    end
  end

  // Two independent lowest-index filters (masked and wrap-around) run in
  // parallel; the mux below picks between them.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    w_masked     = req & w_mask;
    w_masked_idx = '0;
    w_req_idx    = '0;
    // Scan high-to-low so the lowest set index is the last one written.
    for (int i = num_ports - 1; i >= 0; i--) begin
      if (w_masked[i]) w_masked_idx = idx_width'(i);
      if (req[i])      w_req_idx    = idx_width'(i);
    end
  end

  // Winner selection: the owner while locked, otherwise the filter result.
  always_comb begin
    w_owner_oh  = '0;
    for (int i = 0; i < num_ports; i++) begin
      w_owner_oh[i] = (r_owner == idx_width'(i));
    end
    if (r_locked) begin
      w_win_idx   = r_owner;
      w_win_valid = |(req & w_owner_oh);
    end else begin
      w_win_idx   = (|w_masked) ? w_masked_idx : w_req_idx;
      w_win_valid = |req;
    end
  end

  // One-hot grant, tail of the granted flit, and the rotated pointer.
  always_comb begin
    w_gnt       = '0;
    w_prio_next = '0;
    for (int i = 0; i < num_ports; i++) begin
      w_gnt[i] = ready & w_win_valid & (w_win_idx == idx_width'(i));
    end
    for (int i = 0; i < num_ports; i++) begin
      w_prio_next[(i + 1) % num_ports] = w_gnt[i];
    end
    w_win_tail = |(tail & w_gnt);
  end

  assign gnt       = w_gnt;
  assign gnt_valid = |w_gnt;
  assign gnt_idx   = gnt_valid ? w_win_idx : r_last_idx;
  assign locked    = r_locked;

  // State update: only a grant moves the pointer, last index and lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_prio     <= num_ports'(1);
      r_locked   <= 1'b0;
      r_owner    <= '0;
      r_last_idx <= '0;
    end else if (gnt_valid) begin
      r_prio     <= w_prio_next;
      r_last_idx <= w_win_idx;
      if (w_win_tail) begin
        r_locked <= 1'b0;
      end else begin
        r_locked <= 1'b1;
        r_owner  <= w_win_idx;
      end
    end
  end

endmodule

// File: tb/tb_c_rr_packet_arbiter.sv
// Self-checking bench for c_rr_packet_arbiter with num_ports = 4.
// A table of directed vectors covers fairness, locking, backpressure, the
// owner bubble and wrap-around; reset mid-packet is a hand-written sequence.
module tb_c_rr_packet_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] tail;
  logic       ready;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       locked;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] req;
    logic [3:0] tail;
    logic       ready;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;
    logic       locked;
  } vec_t;

  vec_t vq[$];

  c_rr_packet_arbiter #(.num_ports(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .tail      (tail),
    .ready     (ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] t, input logic rd,
                     input logic [3:0] g, input logic v, input logic [1:0] ix,
                     input logic lk);
    vec_t e;
    e.req = r; e.tail = t; e.ready = rd;
    e.gnt = g; e.valid = v; e.idx = ix; e.locked = lk;
    vq.push_back(e);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //   req   tail  rdy   gnt   vld   idx  locked(before edge)
    // Round-robin fairness, then rotate the pointer back to 0.
    add(4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    // Packet lock: requester 0 sends a 4-flit packet, requester 1 waits.
    add(4'h3, 4'h2, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0);
    add(4'h3, 4'h2, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1);
    add(4'h3, 4'h2, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1);
    add(4'h3, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1);
    add(4'h3, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    // Backpressure: stall two cycles, grant index must hold, then 3 wins.
    add(4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0);
    add(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0);
    add(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0);
    add(4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    // Owner bubble: owner 2 drops req while 3 waits; no grant, lock holds.
    add(4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b0);
    add(4'h8, 4'h8, 1'b1, 4'h0, 1'b0, 2'd2, 1'b1);
    add(4'hC, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1);
    add(4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    // Wrap-around: 3 alone three more times, then {0,3} gives 0 then 3.
    add(4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    add(4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    add(4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    add(4'h9, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0);
    add(4'h9, 4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0);
    // Masked set empty: pointer at 2 with req {0,1} wraps to 0.
    add(4'h6, 4'h6, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    add(4'h3, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0);
    // Stall while locked: lock holds, index holds, then the tail releases.
    add(4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0);
    add(4'h3, 4'h2, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1);
    add(4'h3, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1);

    // Reset state
    reset = 1'b0;
    req   = 4'h0;
    tail  = 4'h0;
    ready = 1'b1;
    #2;
    check("rst gnt",       32'(gnt),       32'h0);
    check("rst gnt_valid", 32'(gnt_valid), 32'h0);
    check("rst gnt_idx",   32'(gnt_idx),   32'h0);
    check("rst locked",    32'(locked),    32'h0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors: drive after an edge, sample on the falling edge.
    foreach (vq[i]) begin
      req   = vq[i].req;
      tail  = vq[i].tail;
      ready = vq[i].ready;
      @(negedge clk);
      check($sformatf("v%0d gnt", i),       32'(gnt),       32'(vq[i].gnt));
      check($sformatf("v%0d gnt_valid", i), 32'(gnt_valid), 32'(vq[i].valid));
      check($sformatf("v%0d gnt_idx", i),   32'(gnt_idx),   32'(vq[i].idx));
      check($sformatf("v%0d locked", i),    32'(locked),    32'(vq[i].locked));
      @(posedge clk);
      #1;
    end

    // Reset mid-packet: lock onto owner 3, then assert reset between edges.
    req   = 4'h8;
    tail  = 4'h0;
    ready = 1'b1;
    @(negedge clk);
    check("mid gnt before lock", 32'(gnt), 32'h8);
    @(posedge clk);
    #1;
    check("mid locked", 32'(locked), 32'h1);
    req = 4'h0;
    #2 reset = 1'b0;
    #1;
    check("async rst locked",    32'(locked),    32'h0);
    check("async rst gnt_valid", 32'(gnt_valid), 32'h0);
    check("async rst gnt_idx",   32'(gnt_idx),   32'h0);
    req  = 4'hF;
    tail = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post rst first gnt", 32'(gnt),     32'h1);
    check("post rst first idx", 32'(gnt_idx), 32'h0);
    check("post rst locked",    32'(locked),  32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post rst second gnt", 32'(gnt), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
